lcd_bus_rx: RTL and testbench
=============================

LCD_BUS_RX -- requirements
Module: lcd_bus_rx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 50 MHz; rising edge.
REQ-002 SHALL have ports: rs  in  1  reset, active-low, asynchronous.
REQ-003 SHALL have ports: lcd_rs  in  1  register select from the HD44780 bus (0 = instruction, 1 = data).
REQ-004 SHALL have ports: lcd_rw  in  1  read/write (1 = read).
REQ-005 SHALL have ports: lcd_e  in  1  enable strobe.
REQ-006 SHALL have ports: lcd_4, lcd_5, lcd_6, lcd_7  in  1 each  data nibble (lcd_7 = MSB).
REQ-007 SHALL have ports: chars  out  256  shadow of the 2x16 display; char 0 (line 1, column 0) in [255:248], char 31 (line 2, column 15) in [7:0].
REQ-008 SHALL have ports: byte_valid  out  1  one-cycle pulse per completed byte.
REQ-009 SHALL have ports: byte_out  out  8  last completed byte.
REQ-010 SHALL have ports: byte_is_data  out  1  lcd_rs value of the last completed byte.
REQ-011 SHALL have ports: mode4  out  1  1 = 4-bit mode active.
REQ-012 SHALL have ports: disp_on  out  1  display-on bit.
REQ-013 SHALL have ports: err  out  1  sticky protocol error.
REQ-014 SHALL have parameters: SYNC_STAGES, default 2, number of synchronizer flops on all bus inputs.

Function
REQ-015 SHALL synchronize all bus inputs and sample lcd_rs and the nibble on the detected falling edge of synchronized lcd_e; byte_valid SHALL assert exactly SYNC_STAGES+2 clk cycles after the lcd_e pin falls.
REQ-016 SHALL run 8-bit mode (mode4=0) from reset: each strobe forms a byte {nibble,4'h0}.
REQ-017 A byte 0x2x received in 8-bit mode SHALL set mode4=1 and clear the nibble phase.
REQ-018 In 4-bit mode, nibble phase HI then LO: the first strobe is [7:4], the second is [3:0], and byte_valid SHALL fire on the second strobe only.
REQ-019 If lcd_rs differs between the HI and LO nibbles, the HI nibble SHALL be discarded, the LO strobe SHALL be taken as a new HI nibble, and err SHALL be set.
REQ-020 Strobes with lcd_rw=1 SHALL be ignored (no phase advance) and SHALL set err.
REQ-021 Instruction 0x01: all 32 chars SHALL be set to 0x20, the address SHALL be set to 0x00, and entry SHALL be set to increment; the clear SHALL complete within the same cycle as byte_valid.
REQ-022 Instructions 0x02/0x03: the address SHALL be set to 0x00 and chars SHALL be unchanged.
REQ-023 Instructions 0x04-0x07: bit1 SHALL select the entry direction (1 = increment).
REQ-024 Instructions 0x08-0x0F: disp_on SHALL be set to bit2.
REQ-025 Instructions 0x20-0x3F received in 4-bit mode: DL=1 SHALL return the block to 8-bit mode; other bits SHALL be ignored.
REQ-026 Instructions 0x80-0xFF: the 7-bit DDRAM address SHALL be set to byte[6:0].
REQ-027 Other instructions (0x10-0x1F, 0x40-0x7F) SHALL be accepted with no effect.
REQ-028 Data byte: if the address is in 0x00-0x0F it SHALL write char[addr]; if in 0x40-0x4F it SHALL write char[16+addr-0x40]; other addresses SHALL be discarded. After any data byte, the address SHALL step by +/-1.
REQ-029 Address wrap on increment SHALL be 0x27 -> 0x40 and 0x67 -> 0x00; on decrement SHALL be 0x00 -> 0x67 and 0x40 -> 0x27.
REQ-030 A data write and its address step SHALL update chars in the same cycle as byte_valid.

Reset
REQ-031 While rs=0, the following SHALL hold: chars all 0x20, byte_valid=0, byte_out=0x00, byte_is_data=0, mode4=0, disp_on=0, err=0, address 0x00, increment entry, phase HI, synchronizers cleared.
REQ-032 Reset asserted mid-byte SHALL discard any partial nibble; the first strobe after release SHALL be treated as an 8-bit-mode byte.

Structure
REQ-033 A shared package lcd_pkg SHALL hold the opcode masks, the line base addresses 0x00/0x40, the wrap limits 0x27/0x67, the SPACE constant 0x20, and the phase/mode encodings.
REQ-034 The block SHALL contain one sub-module, lcd_sync: an SYNC_STAGES-flop synchronizer with falling-edge detect on lcd_e.

Verification
REQ-035 Init sequence of nibbles 0x3, 0x3, 0x3, 0x2 -> mode4=1 after the 4th strobe; 4 byte_valid pulses.
REQ-036 4-bit mode, instruction 0x01, then data "Hi" -> chars[255:240]=0x4869, rest 0x20, address 0x02.
REQ-037 Instruction 0xC0 then 16 data bytes 'A'..'P' -> chars[127:0]="ABCDEFGHIJKLMNOP", address 0x50, then 0x80 'Z' -> chars[255:248]=0x5A.
REQ-038 Instructions 0x04 and 0x80, then data 'x' -> char 0 = 'x', address 0x67; then 0xA7 'q' -> address 0x26, no chars change.
REQ-039 lcd_rs toggles between nibbles -> err=1, no byte_valid on that strobe; strobe with lcd_rw=1 -> phase unchanged.
REQ-040 rs pulsed low after a HI nibble -> all outputs at reset values; the next strobe is decoded as an 8-bit byte.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the HD44780 bus receiver: opcode masks,
// DDRAM line layout and the phase/mode encodings.
package lcd_pkg;

  typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_t;
  typedef enum logic {MODE8 = 1'b0, MODE4 = 1'b1} mode_t;

  localparam logic [7:0] SPACE = 8'h20;

  // Instructions are identified by their most significant set bit.
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  localparam int ENTRY_ID_BIT = 1;
  localparam int DISP_D_BIT   = 2;
  localparam int FUNC_DL_BIT  = 4;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_WRAP = 7'h27;
  localparam logic [6:0] LINE2_WRAP = 7'h67;
  localparam logic [6:0] LINE_MASK  = 7'h70;
  localparam int         NUM_CHARS  = 32;

  // Bit positions of the bus signals inside the synchronizer word.
  localparam int BUS_W  = 7;
  localparam int BUS_RS = 6;
  localparam int BUS_RW = 5;
  localparam int BUS_E  = 4;

  function automatic logic [7:0] lead_op(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = 8'(1) << i;
    end
    return r;
  endfunction

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == LINE1_WRAP)      r = LINE2_BASE;
      else if (a == LINE2_WRAP) r = LINE1_BASE;
      else                      r = a + 7'd1;
    end else begin
      if (a == LINE1_BASE)      r = LINE2_WRAP;
      else if (a == LINE2_BASE) r = LINE1_WRAP;
      else                      r = a - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Multi-flop synchronizer for the HD44780 bus with falling-edge detect on E;
// presents the bus sample taken at the detected edge together with a strobe.
module lcd_sync
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [3:0] nib,
  output logic       vld_p0,
  output logic       rs_p0,
  output logic       rw_p0,
  output logic [3:0] nib_p0
);

  logic [BUS_W-1:0] stg [SYNC_STAGES];
  logic             e_prev;
  logic             fall;

  assign fall = e_prev & ~stg[SYNC_STAGES-1][BUS_E];

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
      e_prev <= 1'b0;
      vld_p0 <= 1'b0;
      rs_p0  <= 1'b0;
      rw_p0  <= 1'b0;
      nib_p0 <= '0;
    end else begin
      stg[0] <= {lcd_rs, lcd_rw, lcd_e, nib};
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      e_prev <= stg[SYNC_STAGES-1][BUS_E];
      // stage p0: strobe and bus sample registered together
      vld_p0 <= fall;
      if (fall) begin
        rs_p0  <= stg[SYNC_STAGES-1][BUS_RS];
        rw_p0  <= stg[SYNC_STAGES-1][BUS_RW];
        nib_p0 <= stg[SYNC_STAGES-1][3:0];
      end
    end
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// Passive HD44780 bus listener: assembles bytes in 8/4-bit mode and keeps a
// shadow copy of the 2x16 character display.
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic         lcd_4,
  input  logic         lcd_5,
  input  logic         lcd_6,
  input  logic         lcd_7,
  output logic [255:0] chars,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_is_data,
  output logic         mode4,
  output logic         disp_on,
  output logic         err
);

  logic       vld_p0;
  logic       rs_p0;
  logic       rw_p0;
  logic [3:0] nib_p0;

  lcd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rs     (rs),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_e  (lcd_e),
    .nib    ({lcd_7, lcd_6, lcd_5, lcd_4}),
    .vld_p0 (vld_p0),
    .rs_p0  (rs_p0),
    .rw_p0  (rw_p0),
    .nib_p0 (nib_p0)
  );

  phase_t     phase, phase_nxt;
  mode_t      mode, mode_nxt;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       hi_ld;
  logic       err_set;
  logic       done;
  logic [7:0] byte_asm;
  logic [6:0] addr;
  logic       inc;
  logic [7:0] ch [NUM_CHARS];
  logic       wr_hit;
  logic [4:0] wr_idx;

  always_comb begin
    phase_nxt = phase;
    mode_nxt  = mode;
    hi_ld     = 1'b0;
    err_set   = 1'b0;
    done      = 1'b0;
    byte_asm  = '0;
    if (vld_p0) begin
      if (rw_p0) begin
        err_set = 1'b1;
      end else if (mode == MODE8) begin
        done     = 1'b1;
        byte_asm = {nib_p0, 4'h0};
      end else if (phase == PH_HI) begin
        hi_ld     = 1'b1;
        phase_nxt = PH_LO;
      end else if (rs_p0 != hi_rs) begin
        // Register-select changed mid-byte: restart with this nibble as HI.
        err_set = 1'b1;
        hi_ld   = 1'b1;
      end else begin
        done      = 1'b1;
        byte_asm  = {hi_nib, nib_p0};
        phase_nxt = PH_HI;
      end
    end
    if (done && !rs_p0 && lead_op(byte_asm) == OP_FUNC) begin
      mode_nxt  = byte_asm[FUNC_DL_BIT] ? MODE8 : MODE4;
      phase_nxt = PH_HI;
    end
  end

  assign wr_hit = ((addr & LINE_MASK) == LINE1_BASE) || ((addr & LINE_MASK) == LINE2_BASE);
  assign wr_idx = {addr[6], addr[3:0]};
  assign mode4  = (mode == MODE4);

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      phase        <= PH_HI;
      mode         <= MODE8;
      hi_nib       <= '0;
      hi_rs        <= 1'b0;
      err          <= 1'b0;
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
      addr         <= LINE1_BASE;
      inc          <= 1'b1;
      disp_on      <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) ch[i] <= SPACE;
    end else begin
      // stage p1: byte completion, decode and display update
      phase      <= phase_nxt;
      mode       <= mode_nxt;
      byte_valid <= done;
      err        <= err | err_set;
      if (hi_ld) begin
        hi_nib <= nib_p0;
        hi_rs  <= rs_p0;
      end
      if (done) begin
        byte_out     <= byte_asm;
        byte_is_data <= rs_p0;
        if (rs_p0) begin
          if (wr_hit) ch[wr_idx] <= byte_asm;
          addr <= step_addr(addr, inc);
        end else begin
          case (lead_op(byte_asm))
            OP_DDRAM: addr    <= byte_asm[6:0];
            OP_DISP:  disp_on <= byte_asm[DISP_D_BIT];
            OP_ENTRY: inc     <= byte_asm[ENTRY_ID_BIT];
            OP_HOME:  addr    <= LINE1_BASE;
            OP_CLEAR: begin
              for (int i = 0; i < NUM_CHARS; i++) ch[i] <= SPACE;
              addr <= LINE1_BASE;
              inc  <= 1'b1;
            end
            OP_CGRAM, OP_FUNC, OP_SHIFT: ;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_pack
    assign chars[8*(NUM_CHARS-1-g) +: 8] = ch[g];
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: drives HD44780 bus strobes and compares the
// outputs against a small character-shadow model.
module tb_lcd_bus_rx;

  localparam int SYNC_STAGES = 2;

  logic         clk = 1'b0;
  logic         rs = 1'b0;
  logic         lcd_rs = 1'b0;
  logic         lcd_rw = 1'b0;
  logic         lcd_e = 1'b0;
  logic         lcd_4 = 1'b0;
  logic         lcd_5 = 1'b0;
  logic         lcd_6 = 1'b0;
  logic         lcd_7 = 1'b0;
  logic [255:0] chars;
  logic         byte_valid;
  logic [7:0]   byte_out;
  logic         byte_is_data;
  logic         mode4;
  logic         disp_on;
  logic         err;

  lcd_bus_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .rs           (rs),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_4        (lcd_4),
    .lcd_5        (lcd_5),
    .lcd_6        (lcd_6),
    .lcd_7        (lcd_7),
    .chars        (chars),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .byte_is_data (byte_is_data),
    .mode4        (mode4),
    .disp_on      (disp_on),
    .err          (err)
  );

  always #10 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         nvalid = 0;
  logic       bv_early, bv_on, bv_after;
  logic [7:0] exp_ch [32];

  always @(negedge clk) if (byte_valid) nvalid++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] exp_chars();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = exp_ch[i];
    return r;
  endfunction

  task automatic exp_clear();
    for (int i = 0; i < 32; i++) exp_ch[i] = 8'h20;
  endtask

  // One E pulse; records byte_valid just before, at and after the expected cycle.
  task automatic strobe(input logic r, input logic w, input logic [3:0] n);
    @(posedge clk); #1;
    lcd_rs = r; lcd_rw = w; {lcd_7, lcd_6, lcd_5, lcd_4} = n;
    repeat (2) @(posedge clk); #1;
    lcd_e = 1'b1;
    repeat (4) @(posedge clk); #1;
    lcd_e = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk); #1;
    bv_early = byte_valid;
    @(posedge clk); #1;
    bv_on = byte_valid;
    @(posedge clk); #1;
    bv_after = byte_valid;
    repeat (2) @(posedge clk);
  endtask

  task automatic send4(input logic r, input logic [7:0] b);
    strobe(r, 1'b0, b[7:4]);
    strobe(r, 1'b0, b[3:0]);
  endtask

  initial begin
    exp_clear();
    repeat (3) @(posedge clk); #1;
    check("rst_chars", chars, exp_chars());
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_is_data", byte_is_data, 0);
    check("rst_mode4", mode4, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_err", err, 0);
    rs = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Init sequence in 8-bit mode, first strobe with exact latency check
    nvalid = 0;
    strobe(1'b0, 1'b0, 4'h3);
    check("lat_early", bv_early, 0);
    check("lat_on", bv_on, 1);
    check("lat_after", bv_after, 0);
    check("init_byte1", byte_out, 8'h30);
    check("init_mode_after_30", mode4, 0);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h2);
    check("init_pulses", nvalid, 4);
    check("init_mode4", mode4, 1);
    check("init_byte_out", byte_out, 8'h20);

    // 4-bit configuration, clear, "Hi"
    send4(1'b0, 8'h28);
    check("func_28_mode4", mode4, 1);
    send4(1'b0, 8'h0C);
    check("disp_on_set", disp_on, 1);
    send4(1'b0, 8'h06);
    send4(1'b0, 8'h01);
    check("clear_chars", chars, exp_chars());
    send4(1'b1, 8'h48);
    send4(1'b1, 8'h69);
    exp_ch[0] = 8'h48; exp_ch[1] = 8'h69;
    check("hi_top", chars[255:240], 16'h4869);
    check("hi_chars", chars, exp_chars());
    check("hi_is_data", byte_is_data, 1);
    check("hi_byte_out", byte_out, 8'h69);
    send4(1'b1, 8'h21);
    exp_ch[2] = 8'h21;
    check("addr_after_hi", chars, exp_chars());

    // Line 2 fill, out-of-range write, back to line 1
    send4(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) begin
      send4(1'b1, 8'h41 + 8'(i));
      exp_ch[16+i] = 8'h41 + 8'(i);
    end
    check("line2_text", chars[127:0], 128'h4142434445464748494A4B4C4D4E4F50);
    send4(1'b1, 8'h7A);
    check("addr50_discard", chars, exp_chars());
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h5A);
    exp_ch[0] = 8'h5A;
    check("char0_Z", chars[255:248], 8'h5A);

    // Decrement from 0x00 wraps to 0x67, increment from 0x67 wraps to 0x00
    send4(1'b0, 8'h04);
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h78);
    exp_ch[0] = 8'h78;
    check("char0_x", chars, exp_chars());
    send4(1'b0, 8'h06);
    send4(1'b1, 8'h6B);
    send4(1'b1, 8'h6D);
    exp_ch[0] = 8'h6D;
    check("wrap_67_00", chars, exp_chars());

    // 0xA7 'q' decrementing: nothing visible, address lands on 0x26
    send4(1'b0, 8'h04);
    send4(1'b0, 8'hA7);
    send4(1'b1, 8'h71);
    check("a7_no_change", chars, exp_chars());
    send4(1'b0, 8'h06);
    send4(1'b1, 8'h72);
    send4(1'b1, 8'h73);
    send4(1'b1, 8'h74);
    exp_ch[16] = 8'h74;
    check("wrap_27_40", chars, exp_chars());

    // Decrement from 0x40 wraps to 0x27; 24 discards reach 0x0F
    send4(1'b0, 8'h04);
    send4(1'b0, 8'hC0);
    send4(1'b1, 8'h75);
    exp_ch[16] = 8'h75;
    for (int i = 0; i < 24; i++) send4(1'b1, 8'h2E);
    send4(1'b1, 8'h76);
    exp_ch[15] = 8'h76;
    check("wrap_40_27", chars, exp_chars());

    // Return home, display off
    send4(1'b0, 8'h06);
    send4(1'b0, 8'h02);
    send4(1'b1, 8'h68);
    exp_ch[0] = 8'h68;
    check("home", chars, exp_chars());
    send4(1'b0, 8'h08);
    check("disp_off", disp_on, 0);

    // Register-select change between nibbles, then a read strobe
    check("err_clean", err, 0);
    strobe(1'b0, 1'b0, 4'h8);
    strobe(1'b1, 1'b0, 4'h4);
    check("rs_toggle_no_valid", bv_on, 0);
    check("rs_toggle_err", err, 1);
    strobe(1'b1, 1'b1, 4'h0);
    check("rw_no_valid", bv_on, 0);
    strobe(1'b1, 1'b0, 4'h1);
    check("rw_phase_kept", bv_on, 1);
    check("resync_byte", byte_out, 8'h41);
    exp_ch[1] = 8'h41;
    check("resync_chars", chars, exp_chars());

    // Function set with DL=1 returns to 8-bit mode
    send4(1'b0, 8'h30);
    check("dl1_mode8", mode4, 0);
    check("dl1_byte", byte_out, 8'h30);
    strobe(1'b1, 1'b0, 4'h4);
    exp_ch[2] = 8'h40;
    check("mode8_data", chars, exp_chars());

    // Reset after a HI nibble
    strobe(1'b0, 1'b0, 4'h2);
    check("back_mode4", mode4, 1);
    strobe(1'b0, 1'b0, 4'h8);
    @(posedge clk); #1;
    rs = 1'b0;
    repeat (3) @(posedge clk); #1;
    exp_clear();
    check("mid_rst_chars", chars, exp_chars());
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_byte", byte_out, 0);
    check("mid_rst_is_data", byte_is_data, 0);
    check("mid_rst_mode4", mode4, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_disp", disp_on, 0);
    rs = 1'b1;
    repeat (2) @(posedge clk); #1;
    strobe(1'b0, 1'b0, 4'h3);
    check("post_rst_valid", bv_on, 1);
    check("post_rst_byte", byte_out, 8'h30);
    check("post_rst_mode", mode4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
